queue_word_serializer: RTL and testbench
========================================

// Module: queue_word_serializer
// PURPOSE
//  Read-side consumer for the synchronous word queue. Pops DATA_SIZE-bit words
//  from a queue read port (rvalid/rready/rdata) and emits them as BEATS narrow
//  beats on a valid/ready stream, e.g. toward a byte-wide UART TX or debug port.
//  Sustains one beat per cycle with no bubble between consecutive words.
// PARAMETERS
//  DATA_SIZE  32  width of a queue word; must be a multiple of BEAT_SIZE
//  BEAT_SIZE  8   width of one output beat
//  MSB_FIRST  0   0: beat 0 = word[BEAT_SIZE-1:0]; 1: beat 0 = top BEAT_SIZE bits
//  (derived) BEATS = DATA_SIZE/BEAT_SIZE; CNT_W = max(1,$clog2(BEATS))
// PORTS
//  clk        in   1          single clock, all logic on posedge
//  reset      in   1          synchronous, active-high reset
//  kill       in   1          synchronous flush: drop the word being serialized
//  in_rready  out  1          pop request to queue read port
//  in_rvalid  in   1          queue has a word
//  in_rdata   in   DATA_SIZE  queue head word (valid when in_rvalid)
//  out_valid  out  1          beat available
//  out_ready  in   1          downstream accepts beat
//  out_data   out  BEAT_SIZE  current beat
//  out_last   out  1          current beat is the final beat of its word
//  busy       out  1          word held (state == SEND)
// BEHAVIOUR
//  - Regs: state {IDLE,SEND}, shreg[DATA_SIZE], cnt[CNT_W].
//  - Reset (reset=1 at posedge): state=IDLE, cnt=0, shreg=0. Outputs after reset:
//    out_valid=0, out_last=0, busy=0, out_data=0, in_rready=1.
//  - reset has priority over kill; kill has priority over all handshakes.
//  - in_rready = !kill && (state==IDLE || (state==SEND && out_last && out_ready)).
//    Never depends on in_rvalid. Pop occurs when in_rready && in_rvalid.
//  - Pop: shreg<=in_rdata, cnt<=0, state<=SEND. Latency: word popped at edge N,
//    beat 0 visible on out_* in the cycle after edge N.
//  - SEND: out_valid=1; out_data=shreg low BEAT_SIZE bits (MSB_FIRST=0) or high
//    bits (MSB_FIRST=1); out_last=(cnt==BEATS-1). IDLE: out_valid=0, out_last=0.
//  - Beat handshake (out_valid && out_ready), not last: shift shreg by BEAT_SIZE
//    toward the read end (zero-fill), cnt<=cnt+1.
//  - Last beat handshake: if pop in same cycle, load new word, stay SEND
//    (back-to-back, no bubble); else state<=IDLE.
//  - out_valid && !out_ready: out_data, out_last, cnt, shreg held stable.
//  - BEATS==1: every beat is last; block acts as a one-entry register stage.
//  - kill: state<=IDLE, cnt<=0; the held word is discarded; no pop that cycle.
//    out_* reflect current state during the kill cycle (combinational from regs).
//  - Words are never reordered, duplicated, or partially re-sent.
// STRUCTURE
//  - State enum local to module; no shared-package typedefs required.
//  - Single module, no sub-modules; shift/count datapath plus 2-state FSM.
//  - Elaboration-time check: DATA_SIZE % BEAT_SIZE == 0, else $error.
// TESTING
//  1 Reset: assert reset 2 cycles with in_rvalid=1 -> no pop, out_valid=0,
//    in_rready=1 the cycle after release.
//  2 Single word 32'hDDCCBBAA, out_ready=1, MSB_FIRST=0 -> beats AA,BB,CC,DD on
//    4 consecutive cycles, out_last only on DD, then out_valid=0.
//  3 Back-to-back words 32'h03020100, 32'h07060504 queued, out_ready=1 ->
//    beats 00..07 on 8 consecutive cycles, exactly 2 pops, last on 03 and 07.
//  4 Backpressure: out_ready toggles 1,0,0,1,... -> out_data stable while stalled,
//    byte order unchanged, no pop until last beat accepted.
//  5 Kill after beat 1 of 32'hDDCCBBAA, next word 32'h44332211 queued -> no more
//    beats from first word; next pop yields 11,22,33,44.
//  6 MSB_FIRST=1, word 32'hDDCCBBAA -> beats DD,CC,BB,AA; repeat with BEATS==1
//    (BEAT_SIZE=32) -> one beat per word, out_last=1.

Source files
------------

// File: rtl/queue_word_serializer_pkg.sv
// Shared helpers for the queue word serializer: counter sizing derived from
// the word/beat geometry.
package queue_word_serializer_pkg;

    // Beat counter needs at least one bit even when a word is a single beat.
    function automatic int calc_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/queue_word_serializer.sv
// Pops words from a queue read port and streams them out as narrow beats,
// one beat per cycle, with back-to-back word reload on the final beat.
module queue_word_serializer
    import queue_word_serializer_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int BEAT_SIZE = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 kill,
    output logic                 in_rready,
    input  logic                 in_rvalid,
    input  logic [DATA_SIZE-1:0] in_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BEAT_SIZE-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int BEATS = DATA_SIZE / BEAT_SIZE;
    localparam int CNT_W = calc_cnt_w(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    if (DATA_SIZE % BEAT_SIZE != 0) begin : g_size_check
        $error("queue_word_serializer: DATA_SIZE must be a multiple of BEAT_SIZE");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic pop;
    logic beat_acc;
    logic [DATA_SIZE-1:0] shreg_shifted;

    assign out_valid = (state_q == SEND);
    assign out_last  = (state_q == SEND) && (cnt_q == LAST_CNT);
    assign busy      = (state_q == SEND);
    assign out_data  = MSB_FIRST ? shreg_q[DATA_SIZE-1 -: BEAT_SIZE]
                                 : shreg_q[BEAT_SIZE-1:0];

    // The pop decision never looks at in_rvalid, so the queue sees a stable ready.
    assign in_rready = !kill && ((state_q == IDLE) || (out_last && out_ready));
    assign pop       = in_rready && in_rvalid;
    assign beat_acc  = out_valid && out_ready && !kill;

    assign shreg_shifted = MSB_FIRST ? (shreg_q << BEAT_SIZE) : (shreg_q >> BEAT_SIZE);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (pop) begin
            state_d = SEND;
            shreg_d = in_rdata;
            cnt_d   = '0;
        end else if (beat_acc) begin
            if (out_last) begin
                state_d = IDLE;
            end else begin
                shreg_d = shreg_shifted;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_queue_word_serializer.sv
// Bench for queue_word_serializer: three geometries driven from word queues and
// checked against a per-word beat-list model every cycle.
module tb_queue_word_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  kl, rv, ordy, rr, ov, ol, bz;
    logic [31:0] rd [3];
    logic [7:0]  od0, od1;
    logic [31:0] od2;

    queue_word_serializer #(.DATA_SIZE(32), .BEAT_SIZE(8), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .kill(kl[0]), .in_rready(rr[0]), .in_rvalid(rv[0]),
        .in_rdata(rd[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
        .out_last(ol[0]), .busy(bz[0]));

    queue_word_serializer #(.DATA_SIZE(32), .BEAT_SIZE(8), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .kill(kl[1]), .in_rready(rr[1]), .in_rvalid(rv[1]),
        .in_rdata(rd[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1),
        .out_last(ol[1]), .busy(bz[1]));

    queue_word_serializer #(.DATA_SIZE(32), .BEAT_SIZE(32), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .reset(reset), .kill(kl[2]), .in_rready(rr[2]), .in_rvalid(rv[2]),
        .in_rdata(rd[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2),
        .out_last(ol[2]), .busy(bz[2]));

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] src_q [3][$];
    logic [31:0] eb_q  [3][$];
    logic [31:0] log_q [3][$];
    logic [2:0]  held = 3'b000;
    logic [2:0]  gate = 3'b111;
    int          pops [3];
    bit          armed = 1'b0;

    function automatic int bsz(input int k);
        return (k == 2) ? 32 : 8;
    endfunction

    function automatic bit msb(input int k);
        return (k != 0);
    endfunction

    function automatic logic [31:0] odat(input int k);
        case (k)
            0:       return {24'h0, od0};
            1:       return {24'h0, od1};
            default: return od2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a popped word becomes an ordered list of beats; one leaves per accept.
    task automatic fill(input int k, input logic [31:0] w);
        int nb;
        int sh;
        logic [63:0] m;
        nb = 32 / bsz(k);
        m  = (64'h1 << bsz(k)) - 64'h1;
        for (int i = 0; i < nb; i++) begin
            sh = msb(k) ? (nb - 1 - i) * bsz(k) : i * bsz(k);
            eb_q[k].push_back((w >> sh) & m[31:0]);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic exp_rr;
            exp_rr = !kl[k] && (!held[k] || (eb_q[k].size() == 1 && ordy[k]));
            if (armed) begin
                chk($sformatf("in_rready%0d", k), {31'h0, rr[k]}, {31'h0, exp_rr});
                chk($sformatf("out_valid%0d", k), {31'h0, ov[k]}, {31'h0, held[k]});
                chk($sformatf("busy%0d", k), {31'h0, bz[k]}, {31'h0, held[k]});
                if (held[k]) begin
                    chk($sformatf("out_data%0d", k), odat(k), eb_q[k][0]);
                    chk($sformatf("out_last%0d", k), {31'h0, ol[k]},
                        {31'h0, eb_q[k].size() == 1});
                end else begin
                    chk($sformatf("out_last_idle%0d", k), {31'h0, ol[k]}, 32'h0);
                end
            end
            if (reset || kl[k]) begin
                held[k] = 1'b0;
                eb_q[k].delete();
            end else if (armed) begin
                if (held[k] && ordy[k]) begin
                    log_q[k].push_back(eb_q[k].pop_front());
                    if (eb_q[k].size() == 0) held[k] = 1'b0;
                end
                if (exp_rr && rv[k]) begin
                    fill(k, src_q[k].pop_front());
                    held[k] = 1'b1;
                    pops[k]++;
                end
            end
        end
        if (reset) armed = 1'b1;
    end

    task automatic drive();
        for (int k = 0; k < 3; k++) begin
            rv[k] = gate[k] && (src_q[k].size() > 0);
            rd[k] = rv[k] ? src_q[k][0] : $urandom;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive();
        end
    endtask

    task automatic push_all(input logic [31:0] w);
        for (int k = 0; k < 3; k++) src_q[k].push_back(w);
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 3; k++) begin
            log_q[k].delete();
            pops[k] = 0;
        end
    endtask

    initial begin
        bit done;
        reset = 1'b1;
        kl = '0;
        ordy = 3'b111;
        gate = 3'b111;
        clear_logs();
        push_all(32'hDDCCBBAA);
        drive();

        // Reset held two cycles with a word waiting: nothing may be popped.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_od0", {24'h0, od0}, 32'h0);
        chk("rst_od1", {24'h0, od1}, 32'h0);
        chk("rst_od2", od2, 32'h0);
        chk("rst_rready", {29'h0, rr}, 32'h7);
        chk("rst_pops", pops[0], 0);
        reset = 1'b0;
        drive();

        step(8);
        chk("single_k0_n", log_q[0].size(), 4);
        chk("single_k0_b0", log_q[0][0], 32'hAA);
        chk("single_k0_b3", log_q[0][3], 32'hDD);
        chk("single_k1_b0", log_q[1][0], 32'hDD);
        chk("single_k1_b3", log_q[1][3], 32'hAA);
        chk("single_k2_b0", log_q[2][0], 32'hDDCCBBAA);

        clear_logs();
        push_all(32'h03020100);
        push_all(32'h07060504);
        drive();
        step(12);
        chk("b2b_pops", pops[0], 2);
        chk("b2b_n", log_q[0].size(), 8);
        for (int i = 0; i < 8; i++) chk("b2b_beat", log_q[0][i], i);

        clear_logs();
        push_all(32'hDDCCBBAA);
        push_all(32'h11223344);
        drive();
        for (int c = 0; c < 30; c++) begin
            ordy = (c % 3 == 0) ? 3'b111 : 3'b000;
            step(1);
        end
        ordy = 3'b111;
        step(4);
        chk("bp_n", log_q[0].size(), 8);
        chk("bp_b2", log_q[0][2], 32'hCC);
        chk("bp_b4", log_q[0][4], 32'h44);

        clear_logs();
        push_all(32'hDDCCBBAA);
        push_all(32'h44332211);
        drive();
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step(1);
            if (held[0] && eb_q[0].size() == 2) done = 1'b1;
        end
        chk("kill_reached", {31'h0, done}, 32'h1);
        kl = 3'b111;
        drive();
        step(1);
        kl = 3'b000;
        drive();
        step(8);
        chk("kill_n", log_q[0].size(), 6);
        chk("kill_b1", log_q[0][1], 32'hBB);
        chk("kill_b2", log_q[0][2], 32'h11);
        chk("kill_b5", log_q[0][5], 32'h44);

        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 3) == 0) src_q[k].push_back($urandom);
                gate[k] = ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 2) != 0);
                kl[k]   = !reset && ($urandom_range(0, 39) == 0);
            end
            drive();
        end

        reset = 1'b0;
        kl = '0;
        ordy = 3'b111;
        gate = 3'b111;
        drive();
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            step(1);
            done = (held == 3'b000) && src_q[0].size() == 0 &&
                   src_q[1].size() == 0 && src_q[2].size() == 0;
        end
        chk("drain_done", {31'h0, done}, 32'h1);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
